// File: rtl/fpm_booth_pkg.sv
// Shared types and helpers for the FPM radix-4 Booth mantissa multiplier.
//
// Contents:
//   state_e        - sequencer states of the iterative core
//   booth_digit_t  - one-hot Booth select {one, two, neg}, same encoding as the
//                    partial-product selectors upstream
//   booth_dims_t   - derived widths (N, NDIG, PW, AW) for a given mantissa width
//   booth_dims()   - computes booth_dims_t from the stored mantissa width
//   booth_decode() - maps a 3-bit Booth window onto a booth_digit_t
package fpm_booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_e;

    // Exactly one of one/two is set for a non-zero digit; neg flags a negative digit.
    typedef struct packed {
        logic one;
        logic two;
        logic neg;
    } booth_digit_t;

    typedef struct packed {
        int unsigned n;     // significand width incl. hidden bit
        int unsigned ndig;  // Booth digits walked, one extra for the zero-extended top
        int unsigned pw;    // exact product width
        int unsigned aw;    // accumulator width, 2 bits of headroom for signed partials
    } booth_dims_t;

    // man_w must be odd so that the significand width n is even.
    function automatic booth_dims_t booth_dims(input int unsigned man_w);
        booth_dims_t d;
        d.n    = man_w + 1;
        d.ndig = d.n / 2 + 1;
        d.pw   = 2 * d.n;
        d.aw   = 2 * d.n + 2;
        return d;
    endfunction

    // Window {x[2i+1], x[2i], x[2i-1]} -> digit in {-2, -1, 0, +1, +2}.
    function automatic booth_digit_t booth_decode(input logic [2:0] w);
        booth_digit_t d;
        d = '0;
        unique case (w)
            3'b000, 3'b111: d = '{one: 1'b0, two: 1'b0, neg: 1'b0};
            3'b001, 3'b010: d = '{one: 1'b1, two: 1'b0, neg: 1'b0};
            3'b011:         d = '{one: 1'b0, two: 1'b1, neg: 1'b0};
            3'b100:         d = '{one: 1'b0, two: 1'b1, neg: 1'b1};
            3'b101, 3'b110: d = '{one: 1'b1, two: 1'b0, neg: 1'b1};
            default:        d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fpm_booth_pp_gen.sv
// Radix-4 Booth partial-product generator (combinational).
//
// Ports:
//   window in  3    Booth window {x[2i+1], x[2i], x[2i-1]}
//   y      in  N    multiplicand significand (hidden bit restored)
//   pp     out N+2  ones'-complement partial product (signed, N+2 bits)
//   neg    out 1    digit is negative; the consumer adds this as a carry-in at
//                   the partial product's weight to complete the negation
module fpm_booth_pp_gen
    import fpm_booth_pkg::*;
#(
    parameter int unsigned N = 24
) (
    input  logic [2:0]   window,
    input  logic [N-1:0] y,
    output logic [N+1:0] pp,
    output logic         neg
);

    booth_digit_t dig;
    logic [N+1:0] mag;

    always_comb begin
        dig = booth_decode(window);
        mag = '0;
        if (dig.one) begin
            mag = {2'b00, y};
        end else if (dig.two) begin
            mag = {1'b0, y, 1'b0};
        end
        // Invert only; the +1 goes in as the accumulator carry-in so no extra adder here.
        pp  = dig.neg ? ~mag : mag;
        neg = dig.neg;
    end

endmodule

// File: rtl/fpm_booth_iter_mul.sv
// Iterative radix-4 Booth significand multiplier for the FPM datapath.
// Restores the hidden 1s, then retires one Booth digit per cycle into a signed
// accumulator and presents the exact unnormalised product on a valid/ready port.
//
// Ports:
//   clk       in  1      clock, rising edge
//   rst       in  1      asynchronous active-high reset
//   in_valid  in  1      operand pair valid
//   in_ready  out 1      core idle and accepting
//   a_man     in  MAN_W  multiplicand stored mantissa (hidden 1 implied)
//   b_man     in  MAN_W  multiplier stored mantissa (hidden 1 implied)
//   out_valid out 1      product valid
//   out_ready in  1      downstream accepts product
//   out_prod  out PW     exact product {1,a_man} * {1,b_man}
//   out_ovf   out 1      out_prod[PW-1]: product >= 2.0
module fpm_booth_iter_mul
    import fpm_booth_pkg::*;
#(
    parameter  int unsigned MAN_W = 23,  // must be odd
    localparam booth_dims_t DIMS  = booth_dims(MAN_W),
    localparam int unsigned N     = DIMS.n,
    localparam int unsigned NDIG  = DIMS.ndig,
    localparam int unsigned PW    = DIMS.pw,
    localparam int unsigned AW    = DIMS.aw
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] a_man,
    input  logic [MAN_W-1:0] b_man,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_prod,
    output logic             out_ovf
);

    localparam int unsigned CW = $clog2(NDIG);
    localparam int unsigned XW = N + 3;  // {2'b00, significand, x[-1]}

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] acc_q;
    logic [N-1:0]  y_q;
    logic [XW-1:0] x_q;

    logic [CW:0]   shamt;
    logic [2:0]    window;
    logic [N+1:0]  pp;
    logic          pp_neg;
    logic [AW-1:0] pp_sext;
    logic [AW-1:0] acc_sum;

    fpm_booth_pp_gen #(
        .N (N)
    ) u_pp_gen (
        .window (window),
        .y      (y_q),
        .pp     (pp),
        .neg    (pp_neg)
    );

    // Digit cnt carries weight 4^cnt, i.e. a left shift by 2*cnt.
    always_comb begin
        shamt   = {cnt_q, 1'b0};
        window  = x_q[shamt +: 3];
        pp_sext = {{(AW - N - 2){pp[N+1]}}, pp};
        // Accumulate modulo 2^AW; the neg carry-in completes the two's-complement.
        acc_sum = acc_q + (pp_sext << shamt) + (AW'(pp_neg) << shamt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            x_q       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        y_q      <= {1'b1, a_man};
                        // Zero extension keeps the top digit in {0, +1}, so the
                        // multiplier is treated as unsigned.
                        x_q      <= {2'b00, 1'b1, b_man, 1'b0};
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                        state_q  <= ITER;
                    end
                end
                ITER: begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NDIG - 1)) begin
                        out_valid <= 1'b1;
                        out_prod  <= acc_sum[PW-1:0];
                        out_ovf   <= acc_sum[PW-1];
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    // No accept here: IDLE always sits for one cycle after the handshake.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Product of two N-bit unsigned values never reaches the headroom bits.
    acc_headroom_zero: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == DONE) |-> (acc_q[AW-1:PW] == '0)
    );

endmodule

// File: doc/fpm_booth_iter_mul.md
Name: fpm_booth_iter_mul

Overview:
- Sequential radix-4 Booth mantissa multiplier core for the FPM datapath. Sits directly downstream of the Booth partial-product selectors.
- Takes two 23-bit stored mantissas, restores the hidden 1s, and walks one Booth digit per cycle. Each cycle it selects a signed partial product and accumulates it at the correct weight.
- Returns the exact 48-bit unnormalised significand product to the normalise/round stage through a valid/ready handshake.

Parameters:
- MAN_W, 23, stored mantissa width. Must be odd so that N = MAN_W+1 is even.
- Derived, not overridable: N = MAN_W+1 (24); NDIG = N/2+1 (13 Booth digits); PW = 2N (48 product bits); AW = 2N+2 (50 accumulator bits).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  core idle and accepting
- a_man  in  MAN_W  multiplicand stored mantissa (hidden bit implied 1)
- b_man  in  MAN_W  multiplier stored mantissa (hidden bit implied 1)
- out_valid  out  1  product valid
- out_ready  in  1  downstream accepts product
- out_prod  out  PW  exact product {1,a_man} * {1,b_man}
- out_ovf  out  1  out_prod[PW-1]; product >= 2.0, so downstream shifts right 1

Behaviour:
- Reset: state=IDLE, cnt=0, acc=0, Y=0, X=0, out_valid=0, in_ready=1, out_prod=0, out_ovf=0. Reset asserted mid-operation abandons the operation with no output. The first edge after deassert sees IDLE.
- FSM states: IDLE, ITER, DONE.
- IDLE: in_ready=1. On in_valid&in_ready: Y<={1,a_man}, X<={2'b00,1,b_man,1'b0} (zero-extended, with x[-1]=0 appended), acc<=0, cnt<=0, go to ITER.
- ITER: in_ready=0, out_valid=0. Each cycle:
  - Booth window w = X[2cnt+2:2cnt]. Digit d is: 000/111 -> 0; 001/010 -> +1; 011 -> +2; 100 -> -2; 101/110 -> -1.
  - pp = d*Y as an (N+2)-bit two's-complement value.
  - acc <= acc + (sign-extend(pp) << 2cnt), computed modulo 2^AW.
  - cnt <= cnt+1.
  - When cnt==NDIG-1, that addition is performed and the state goes to DONE.
- DONE: out_valid=1, out_prod=acc[PW-1:0], out_ovf=acc[PW-1].
  - acc[AW-1:PW] must be 0 (checked by assertion).
  - Outputs are held stable while out_ready=0.
  - On out_ready: go to IDLE.
- Latency: an operand pair accepted at edge T makes out_valid high from edge T+NDIG (13 cycles).
- Throughput: one product per NDIG+2 cycles minimum. IDLE always lasts at least 1 cycle after the output handshake; there is no accept in DONE.
- in_valid while busy is ignored; the upstream stage holds its data (in_ready=0).
- a_man/b_man are sampled only at accept, so later changes have no effect.
- Arithmetic: the result equals the unsigned product of the two N-bit significands for every input. The top digit (cnt=NDIG-1) is always 0 or +1 because of the zero extension.

Decomposition:
- Package fpm_booth_pkg holds:
  - state enum {IDLE, ITER, DONE};
  - Booth digit typedef (3-bit one-hot sel {single, double, neg}, matching the selector encoding);
  - the function deriving N/NDIG/PW/AW from MAN_W;
  - the window-to-digit decode function.
- Sub-module fpm_booth_pp_gen: combinational. Inputs are the 3-bit window and Y; output is the (N+2)-bit signed pp. It uses the single/double/neg select with invert-plus-one negation (the +1 is injected into the accumulator carry-in). It is instantiated once in the iterative core.

Test Plan:
- a=b=0x000000 (1.0*1.0) -> out_valid at accept+13, out_prod=0x4000_0000_0000, out_ovf=0.
- a=b=0x400000 (1.5*1.5) -> out_prod=0x9000_0000_0000, out_ovf=1.
- a=b=0x7FFFFF (max) -> out_prod=0xFFFF_FE00_0001, out_ovf=1. Assertion acc[49:48]==0 holds.
- Backpressure: after out_valid, hold out_ready=0 for 5 cycles and toggle a_man/b_man/in_valid -> out_prod stable, in_ready=0, no new accept. Release -> IDLE the next cycle.
- Pulse rst in ITER at cnt=6 -> out_valid=0 and in_ready=1 immediately. Then apply a=0x200000, b=0x000000 -> out_prod=0x5000_0000_0000 with no residue from the aborted run.
- Hold in_valid high with 1000 random pairs and random out_ready -> every product matches the reference model, accepts spaced at least 15 cycles apart, and no drops or duplicates.
